branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
// - Parametrised, registered branch/jump resolution unit in the EX stage of the OoO core.
// - Takes issued BEQ..BGEU/JAL/JALR ops from the branch RS, computes direction, target and link value.
// - Checks each result against the frontend prediction; queues results in a DEPTH-entry FIFO.
// - The FIFO drains to the PC/ROB under valid/ready; flushed on recovery.
// PARAMETERS
// - XLEN      32  data/address width
// - TAG_W     2   branch tag (checkpoint id) width
// - DEPTH     4   result FIFO entries, power of 2, >=2
// - OP_W      6   opcode width, shared package encoding
// PORTS
// - clk          in   1       rising-edge clock
// - rst_n        in   1       asynchronous active-low reset
// - flush        in   1       sync recovery: drop queued and incoming work
// - in_valid     in   1       RS issues an op this cycle
// - in_ready     out  1       unit accepts an op; transfer on in_valid&&in_ready
// - in_op        in   OP_W    BEQ,BNE,BLT,BGE,BLTU,BGEU,JAL,JALR
// - in_rs1       in   XLEN    operand one
// - in_rs2       in   XLEN    operand two
// - in_imm       in   XLEN    sign-extended immediate
// - in_pc        in   XLEN    instruction PC
// - in_pred_tk   in   1       predicted taken
// - in_pred_tgt  in   XLEN    predicted next PC
// - in_tag       in   TAG_W   branch tag
// - out_valid    out  1       FIFO head valid
// - out_ready    in   1       consumer pops head on out_valid&&out_ready
// - out_tag      out  TAG_W   head tag (freed at consumer)
// - out_taken    out  1       resolved direction (JAL/JALR = 1)
// - out_next_pc  out  XLEN    correct next PC
// - out_mispred  out  1       prediction wrong; consumer redirects to out_next_pc
// - out_link     out  XLEN    pc+4 for JAL/JALR, else 0
// BEHAVIOUR
// - Reset: FIFO empty; count=0; out_valid=0; in_ready=1; all data outputs 0.
// - in_ready = (count < DEPTH); independent of out_ready. No bypass. A full FIFO with pop+push does not occur.
// - Latency: op accepted in cycle N appears at the head in cycle N+1 if the FIFO was empty.
// - FIFO order is strict; head output fields are registered FIFO storage.
// - Direction:
//   - BEQ ==, BNE !=, BLTU <, BGEU >= unsigned.
//   - BLT < signed, BGE >= signed.
// - Targets:
//   - Branch/JAL: pc+imm.
//   - JALR: (rs1+imm) & ~1.
//   - Not-taken: pc+4.
//   - All sums mod 2^XLEN; wrap-around is silent.
// - mispred = (taken != pred_tk) || (taken && next_pc != pred_tgt); not-taken compares direction only.
// - Unknown opcode: accepted; taken=0, next_pc=pc+4, mispred=pred_tk, link=0.
// - Simultaneous push and pop: count unchanged; pointers both advance, wrapping at DEPTH.
// - flush (wins over everything): next cycle count=0, out_valid=0, pointers=0.
//   - A same-cycle in_valid is dropped, not enqueued.
//   - A same-cycle pop has no effect.
// - Async reset mid-operation: immediate return to reset state; queued results are lost.
// STRUCTURE
// - Shared package/defines: opcode constants (BEQ..JALR), OP_W, XLEN default, addr_free constant.
// - One sub-module: bru_fifo (parametrised sync FIFO: DEPTH, WIDTH, flush, count).
// - Resolve logic is combinational in the top; packed entry = {tag,taken,mispred,next_pc,link}.
// TESTING
// - Reset during traffic: out_valid=0 and in_ready=1 immediately; resumes cleanly after release.
// - BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred_tk=0: next cycle out_taken=1, next_pc=0x120, mispred=1.
// - BGE rs1=0xFFFFFFFF, rs2=1, pc=0x40, pred_tk=0: taken=0, next_pc=0x44, mispred=0.
//   - Same operands on BGEU: taken=1.
// - JALR rs1=0x1001, imm=2, pc=0x200, pred_tgt=0x1002: next_pc=0x1002, link=0x204, mispred=0.
// - out_ready=0, issue 5 ops (DEPTH=4): in_ready falls after the 4th.
//   - Raise out_ready: tags drain in order; in_ready returns.
// - flush with 3 queued + 1 in_valid: out_valid=0 next cycle, count=0; nothing from the flushed op appears later.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - opcode encoding and shared constants for the branch resolve unit
package branch_resolve_unit_pkg;

  localparam int unsigned BRU_XLEN = 32;
  localparam int unsigned BRU_OP_W = 6;

  localparam logic [BRU_OP_W-1:0] OP_BEQ  = 6'h00;
  localparam logic [BRU_OP_W-1:0] OP_BNE  = 6'h01;
  localparam logic [BRU_OP_W-1:0] OP_BLT  = 6'h04;
  localparam logic [BRU_OP_W-1:0] OP_BGE  = 6'h05;
  localparam logic [BRU_OP_W-1:0] OP_BLTU = 6'h06;
  localparam logic [BRU_OP_W-1:0] OP_BGEU = 6'h07;
  localparam logic [BRU_OP_W-1:0] OP_JAL  = 6'h08;
  localparam logic [BRU_OP_W-1:0] OP_JALR = 6'h09;

  // Link value reported for ops that do not write a return address.
  localparam logic [BRU_XLEN-1:0] ADDR_FREE = '0;

endpackage

// File: rtl/bru_fifo.sv
// rtl/bru_fifo.sv - synchronous result FIFO with flush and occupancy count
module bru_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !flush_i && (count_q < CNT_W'(DEPTH));
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves branch/jump direction, target and link, queues results
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN  = BRU_XLEN,
  parameter int unsigned TAG_W = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OP_W  = BRU_OP_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [OP_W-1:0]  in_op_i,
  input  logic [XLEN-1:0]  in_rs1_i,
  input  logic [XLEN-1:0]  in_rs2_i,
  input  logic [XLEN-1:0]  in_imm_i,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic             in_pred_tk_i,
  input  logic [XLEN-1:0]  in_pred_tgt_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_taken_o,
  output logic [XLEN-1:0]  out_next_pc_o,
  output logic             out_mispred_o,
  output logic [XLEN-1:0]  out_link_o
);

  localparam int unsigned ENTRY_W = TAG_W + 2 + 2*XLEN;
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);

  logic             taken, mispred;
  logic [XLEN-1:0]  br_tgt, jalr_tgt, seq_pc, tgt, next_pc, link;
  logic [ENTRY_W-1:0] wdata, rdata;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  always_comb begin
    br_tgt   = in_pc_i + in_imm_i;
    seq_pc   = in_pc_i + XLEN'(4);
    jalr_tgt = (in_rs1_i + in_imm_i) & ~XLEN'(1);
    taken    = 1'b0;
    tgt      = br_tgt;
    link     = XLEN'(ADDR_FREE);
    case (in_op_i)
      OP_W'(OP_BEQ):  taken = (in_rs1_i == in_rs2_i);
      OP_W'(OP_BNE):  taken = (in_rs1_i != in_rs2_i);
      OP_W'(OP_BLT):  taken = ($signed(in_rs1_i) <  $signed(in_rs2_i));
      OP_W'(OP_BGE):  taken = ($signed(in_rs1_i) >= $signed(in_rs2_i));
      OP_W'(OP_BLTU): taken = (in_rs1_i <  in_rs2_i);
      OP_W'(OP_BGEU): taken = (in_rs1_i >= in_rs2_i);
      OP_W'(OP_JAL): begin
        taken = 1'b1;
        link  = seq_pc;
      end
      OP_W'(OP_JALR): begin
        taken = 1'b1;
        tgt   = jalr_tgt;
        link  = seq_pc;
      end
      default: taken = 1'b0;
    endcase
    next_pc = taken ? tgt : seq_pc;
    // A not-taken prediction carries no meaningful target, so only direction is compared.
    mispred = (taken != in_pred_tk_i) || (taken && (next_pc != in_pred_tgt_i));
  end

  assign in_ready_o  = (count < CNT_W'(DEPTH));
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign wdata       = {in_tag_i, taken, mispred, next_pc, link};

  bru_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .count_o (count)
  );

  assign {out_tag_o, out_taken_o, out_mispred_o, out_next_pc_o, out_link_o} = rdata;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - randomized self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [5:0]  in_op_i = '0;
  logic [31:0] in_rs1_i = '0, in_rs2_i = '0, in_imm_i = '0, in_pc_i = '0, in_pred_tgt_i = '0;
  logic        in_pred_tk_i = 1'b0;
  logic [1:0]  in_tag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [1:0]  out_tag_o;
  logic        out_taken_o, out_mispred_o;
  logic [31:0] out_next_pc_o, out_link_o;

  branch_resolve_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_op_i(in_op_i),
    .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_imm_i(in_imm_i), .in_pc_i(in_pc_i),
    .in_pred_tk_i(in_pred_tk_i), .in_pred_tgt_i(in_pred_tgt_i), .in_tag_i(in_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_tag_o(out_tag_o),
    .out_taken_o(out_taken_o), .out_next_pc_o(out_next_pc_o),
    .out_mispred_o(out_mispred_o), .out_link_o(out_link_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit [1:0]  tag;
    bit        taken;
    bit        mispred;
    bit [31:0] next_pc;
    bit [31:0] link;
  } exp_t;

  exp_t     q[$];
  bit [1:0] drained[$];
  int       total = 0;
  int       bad = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  function automatic exp_t predict(bit [5:0] op, bit [31:0] rs1, bit [31:0] rs2, bit [31:0] imm,
                                   bit [31:0] pc, bit ptk, bit [31:0] ptgt, bit [1:0] tag);
    exp_t      e;
    bit [31:0] dest;
    bit        is_jump;
    e.tag   = tag;
    e.taken = 0;
    dest    = pc + imm;
    is_jump = 0;
    case (op)
      OP_BEQ:  e.taken = (rs1 == rs2);
      OP_BNE:  e.taken = (rs1 != rs2);
      OP_BLT:  e.taken = ($signed(rs1) < $signed(rs2));
      OP_BGE:  e.taken = !($signed(rs1) < $signed(rs2));
      OP_BLTU: e.taken = (rs1 < rs2);
      OP_BGEU: e.taken = !(rs1 < rs2);
      OP_JAL:  begin e.taken = 1; is_jump = 1; end
      OP_JALR: begin e.taken = 1; is_jump = 1; dest = rs1 + imm; dest[0] = 1'b0; end
      default: e.taken = 0;
    endcase
    e.next_pc = e.taken ? dest : pc + 32'd4;
    e.link    = is_jump ? pc + 32'd4 : 32'd0;
    e.mispred = (e.taken != ptk) || (e.taken && e.next_pc != ptgt);
    return e;
  endfunction

  // One clock: check outputs mid-cycle, advance the model, return at posedge+1.
  task automatic tick(output bit acc);
    bit   push, pop;
    exp_t e;
    #4;
    chk("in_ready", in_ready_o, q.size() < DEPTH);
    chk("out_valid", out_valid_o, q.size() != 0);
    if (q.size() != 0) begin
      chk("head_tag", out_tag_o, q[0].tag);
      chk("head_taken", out_taken_o, q[0].taken);
      chk("head_next_pc", out_next_pc_o, q[0].next_pc);
      chk("head_mispred", out_mispred_o, q[0].mispred);
      chk("head_link", out_link_o, q[0].link);
    end
    push = in_valid_i && (q.size() < DEPTH);
    pop  = out_ready_i && (q.size() != 0);
    acc  = 0;
    if (flush_i) begin
      q.delete();
    end else begin
      if (push) e = predict(in_op_i, in_rs1_i, in_rs2_i, in_imm_i, in_pc_i,
                            in_pred_tk_i, in_pred_tgt_i, in_tag_i);
      if (pop) begin
        drained.push_back(out_tag_o);
        void'(q.pop_front());
      end
      if (push) q.push_back(e);
      acc = push;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit [5:0] op, input bit [31:0] rs1, input bit [31:0] rs2,
                       input bit [31:0] imm, input bit [31:0] pc, input bit ptk,
                       input bit [31:0] ptgt, input bit [1:0] tag);
    in_op_i = op; in_rs1_i = rs1; in_rs2_i = rs2; in_imm_i = imm; in_pc_i = pc;
    in_pred_tk_i = ptk; in_pred_tgt_i = ptgt; in_tag_i = tag;
  endtask

  task automatic send(input bit [5:0] op, input bit [31:0] rs1, input bit [31:0] rs2,
                      input bit [31:0] imm, input bit [31:0] pc, input bit ptk,
                      input bit [31:0] ptgt, input bit [1:0] tag);
    bit acc;
    acc = 0;
    drive(op, rs1, rs2, imm, pc, ptk, ptgt, tag);
    in_valid_i = 1;
    for (int n = 0; n < 50 && !acc; n++) tick(acc);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid_i = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    exp_t e;
    bit [5:0]  op;
    bit [31:0] rs1, rs2, imm, pc, ptgt;
    bit        ptk;

    #12;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_next_pc", out_next_pc_o, 0);
    chk("rst_link", out_link_o, 0);
    chk("rst_flags", {out_tag_o, out_taken_o, out_mispred_o}, 0);
    rst_ni = 1;
    @(posedge clk_i);
    #1;

    send(OP_BEQ, 5, 5, 32'h20, 32'h100, 0, 0, 2'd1);
    chk("beq_taken", out_taken_o, 1);
    chk("beq_next_pc", out_next_pc_o, 32'h120);
    chk("beq_mispred", out_mispred_o, 1);
    tick(acc);

    send(OP_BGE, 32'hFFFF_FFFF, 1, 32'h10, 32'h40, 0, 0, 2'd2);
    chk("bge_taken", out_taken_o, 0);
    chk("bge_next_pc", out_next_pc_o, 32'h44);
    chk("bge_mispred", out_mispred_o, 0);
    tick(acc);

    send(OP_BGEU, 32'hFFFF_FFFF, 1, 32'h10, 32'h40, 0, 0, 2'd3);
    chk("bgeu_taken", out_taken_o, 1);
    tick(acc);

    send(OP_JALR, 32'h1001, 0, 2, 32'h200, 1, 32'h1002, 2'd0);
    chk("jalr_next_pc", out_next_pc_o, 32'h1002);
    chk("jalr_link", out_link_o, 32'h204);
    chk("jalr_mispred", out_mispred_o, 0);
    tick(acc);

    // Fill to DEPTH with the consumer stalled, then drain.
    out_ready_i = 0;
    drained.delete();
    for (int i = 0; i < 4; i++) send(OP_JAL, 0, 0, 32'h8, 32'h1000 + 32'(i*4), 1, 0, 2'(i));
    chk("full_in_ready", in_ready_o, 0);
    drive(OP_BNE, 1, 2, 32'h40, 32'h2000, 1, 32'h2040, 2'd1);
    in_valid_i = 1;
    tick(acc);
    chk("full_no_accept", acc, 0);
    out_ready_i = 1;
    for (int n = 0; n < 20 && !acc; n++) tick(acc);
    in_valid_i = 0;
    for (int n = 0; n < 20 && q.size() != 0; n++) tick(acc);
    chk("drain_count", drained.size(), 5);
    for (int i = 0; i < 5 && i < drained.size(); i++) chk("drain_order", drained[i], (i == 4) ? 1 : i);
    chk("drain_in_ready", in_ready_o, 1);

    // Flush with three queued and one incoming.
    out_ready_i = 0;
    for (int i = 0; i < 3; i++) send(OP_BNE, 32'(i), 9, 32'h10, 32'h300, 0, 0, 2'(i));
    drive(OP_JAL, 0, 0, 32'h80, 32'h400, 0, 0, 2'd3);
    in_valid_i = 1;
    flush_i = 1;
    tick(acc);
    flush_i = 0;
    in_valid_i = 0;
    chk("flush_out_valid", out_valid_o, 0);
    chk("flush_in_ready", in_ready_o, 1);
    out_ready_i = 1;
    drained.delete();
    repeat (5) tick(acc);
    chk("flush_nothing_later", drained.size(), 0);

    // Asynchronous reset with results queued.
    out_ready_i = 0;
    send(OP_JAL, 0, 0, 32'h10, 32'h500, 1, 32'h510, 2'd2);
    send(OP_BLT, 32'h8000_0000, 0, 32'h10, 32'h600, 1, 32'h610, 2'd3);
    #2;
    rst_ni = 0;
    #1;
    chk("arst_out_valid", out_valid_o, 0);
    chk("arst_in_ready", in_ready_o, 1);
    q.delete();
    repeat (2) @(posedge clk_i);
    #3;
    rst_ni = 1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1;
    send(OP_JAL, 0, 0, 32'h10, 32'h700, 1, 32'h710, 2'd1);
    chk("arst_resume_next_pc", out_next_pc_o, 32'h710);
    chk("arst_resume_link", out_link_o, 32'h704);
    tick(acc);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 9))
        0: op = OP_BEQ;  1: op = OP_BNE;  2: op = OP_BLT;  3: op = OP_BGE;
        4: op = OP_BLTU; 5: op = OP_BGEU; 6: op = OP_JAL;  7: op = OP_JALR;
        8: op = 6'h3F;
        default: op = 6'($urandom_range(10, 62));
      endcase
      rs1 = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : (($urandom_range(0, 1) != 0) ? $urandom : rs1 ^ 32'h8000_0000);
      imm = ($urandom_range(0, 1) != 0) ? 32'($signed($urandom_range(0, 4095)) - 2048) : $urandom;
      pc  = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      e   = predict(op, rs1, rs2, imm, pc, 0, 0, 0);
      ptk  = ($urandom_range(0, 2) != 0) ? e.taken : 1'($urandom);
      ptgt = ($urandom_range(0, 2) != 0) ? e.next_pc : $urandom;
      drive(op, rs1, rs2, imm, pc, ptk, ptgt, 2'($urandom));
      in_valid_i  = ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 6);
      flush_i     = ($urandom_range(0, 32) == 0);
      tick(acc);
    end
    flush_i = 0;
    in_valid_i = 0;
    out_ready_i = 1;
    repeat (6) tick(acc);
    chk("final_empty", out_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
